// File: rtl/gshare_pht.sv
// gshare pattern history table: 2^HIST_BITS two-bit saturating counters
// indexed by (fetch PC word bits ^ global history). Registered prediction,
// write-first bypass on same-index update, and combinational forwarding of
// resolved outcomes to the global history register.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | sweeping init_cnt over every entry, writing weak-NT (01)
// S_RUN  | table valid; predictions and training accepted
module gshare_pht #(
  parameter int HIST_BITS = 10,
  parameter int PC_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [HIST_BITS-1:0] history,
  input  logic                 pred_valid,
  input  logic [PC_BITS-1:0]   pred_pc,
  output logic                 pred_out_valid,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [HIST_BITS-1:0] upd_idx,
  input  logic                 upd_taken,
  output logic                 ghr_valid,
  output logic                 ghr_bit,
  output logic                 ready
);

  localparam int ENTRIES = 1 << HIST_BITS;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state;
  logic [HIST_BITS-1:0] init_cnt;
  logic [1:0]           pht [ENTRIES];

  logic                 run;
  logic [HIST_BITS-1:0] rd_idx;
  logic [1:0]           rd_ctr;
  logic [1:0]           upd_ctr;
  logic [1:0]           upd_next;
  logic                 wr_en;
  logic [HIST_BITS-1:0] wr_idx;
  logic [1:0]           wr_data;
  logic                 unused_pc;

  function automatic logic [1:0] train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // PC byte-offset bits and bits above the index never reach the table
  assign unused_pc = ^{pred_pc[PC_BITS-1:HIST_BITS+2], pred_pc[1:0]};

  assign run      = (state == S_RUN);
  assign ready    = run;
  assign rd_idx   = pred_pc[HIST_BITS+1:2] ^ history;
  assign upd_ctr  = pht[upd_idx];
  assign upd_next = train(upd_ctr, upd_taken);

  // Write-first: a same-cycle update to the read index is seen by the read
  assign rd_ctr = (upd_valid && (upd_idx == rd_idx)) ? upd_next : pht[rd_idx];

  // History shifts on the same edge the counter is trained; nothing during INIT
  assign ghr_valid = run && upd_valid && !reset;
  assign ghr_bit   = upd_taken;

  // Table write port: init sweep in INIT, training in RUN
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = init_cnt;
    wr_data = 2'b01;
    if (!reset) begin
      if (run) begin
        wr_en   = upd_valid;
        wr_idx  = upd_idx;
        wr_data = upd_next;
      end else begin
        wr_en   = 1'b1;
      end
    end
  end

  // Counter storage; contents are not reset, the INIT sweep defines them
  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

  // Init/run sequencing and registered prediction outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_INIT;
      init_cnt       <= '0;
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_idx       <= '0;
    end else begin
      case (state)
        S_INIT: begin
          pred_out_valid <= 1'b0;
          init_cnt       <= init_cnt + 1'b1;
          if (init_cnt == '1) state <= S_RUN;
        end
        default: begin
          pred_out_valid <= pred_valid;
          if (pred_valid) begin
            pred_taken <= rd_ctr[1];
            pred_idx   <= rd_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed test-plan scenarios plus a
// randomized phase, all checked against an array-of-integers counter model.
module tb_gshare_pht;

  localparam int HB = 10;
  localparam int N  = 1 << HB;

  logic          clk = 1'b0;
  logic          reset;
  logic [HB-1:0] history;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_out_valid;
  logic          pred_taken;
  logic [HB-1:0] pred_idx;
  logic          upd_valid;
  logic [HB-1:0] upd_idx;
  logic          upd_taken;
  logic          ghr_valid;
  logic          ghr_bit;
  logic          ready;

  int errors = 0;
  int checks = 0;
  int model [N];

  gshare_pht #(.HIST_BITS(HB), .PC_BITS(32)) dut (
    .clk(clk), .reset(reset), .history(history), .pred_valid(pred_valid),
    .pred_pc(pred_pc), .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_idx(pred_idx), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .ghr_valid(ghr_valid), .ghr_bit(ghr_bit), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int train(input int c, input bit taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    else       return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    pred_valid = 1'b0;
    upd_valid  = 1'b1;
    upd_taken  = 1'b1;
    upd_idx    = '0;
    tick();
    tick();
    check("rst_pov", pred_out_valid, 0);
    check("rst_ptaken", pred_taken, 0);
    check("rst_pidx", pred_idx, 0);
    check("rst_ready", ready, 0);
    check("rst_ghr_valid", ghr_valid, 0);
    reset     = 1'b0;
    upd_valid = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 1;
  endtask

  // Counts edges after deassertion; optionally fires an update/request at cycle 10
  task automatic wait_init(input bit poke);
    for (int c = 1; c <= N; c++) begin
      tick();
      if (c == 11 && poke) begin
        check("init_pov", pred_out_valid, 0);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
      end
      if (c == N - 1) check("ready_low_last", ready, 0);
      else if (c == N) check("ready_rise", ready, 1);
      else if (ready !== 1'b0) check("ready_early", ready, 0);
      if (c == 10 && poke) begin
        pred_valid = 1'b1;
        pred_pc    = 32'h24;
        history    = '0;
        upd_valid  = 1'b1;
        upd_idx    = 10'd9;
        upd_taken  = 1'b1;
        #1;
        check("init_ghr_valid", ghr_valid, 0);
      end
    end
  endtask

  // One RUN cycle: drive, check forwarding, advance model, check prediction
  task automatic cyc(input bit pv, input logic [31:0] pc, input logic [HB-1:0] hist,
                     input bit uv, input logic [HB-1:0] ui, input bit ut);
    int idx;
    pred_valid = pv;
    pred_pc    = pc;
    history    = hist;
    upd_valid  = uv;
    upd_idx    = ui;
    upd_taken  = ut;
    #1;
    check("ghr_valid", ghr_valid, uv);
    if (uv) begin
      check("ghr_bit", ghr_bit, ut);
      model[ui] = train(model[ui], ut);
    end
    idx = ((pc >> 2) & (N - 1)) ^ hist;
    tick();
    check("pov", pred_out_valid, pv);
    if (pv) begin
      check("ptaken", pred_taken, (model[idx] >= 2) ? 1 : 0);
      check("pidx", pred_idx, idx);
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic predict(input int idx);
    cyc(1'b1, 32'(idx) << 2, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic update(input int idx, input bit t);
    cyc(1'b0, 32'h0, '0, 1'b1, HB'(idx), t);
  endtask

  initial begin
    history    = '0;
    pred_pc    = '0;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_taken  = 1'b0;
    reset      = 1'b1;

    apply_reset();
    wait_init(1'b1);

    // Every entry reads weak NT after init, including the one poked during INIT
    for (int i = 0; i < N; i++) predict(i);

    // Index formation from PC and history
    cyc(1'b1, 32'h0000_0010, 10'h3FF, 1'b0, '0, 1'b0);
    check("dir_idx_const", pred_idx, 10'h3FB);
    cyc(1'b0, 32'h0, '0, 1'b0, '0, 1'b0);

    // Saturation on idx 5
    for (int k = 0; k < 3; k++) begin update(5, 1'b1); predict(5); end
    for (int k = 0; k < 7; k++) begin update(5, 1'b0); predict(5); end
    check("sat_floor", model[5], 0);

    // Same-cycle bypass on idx 7 (weak NT -> weak T)
    cyc(1'b1, 32'h0000_001C, '0, 1'b1, 10'd7, 1'b1);
    check("bypass_taken", pred_taken, 1);

    // Randomized traffic focused on a few entries to hit collisions and saturation
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      logic [HB-1:0] tgt, hist, ui;
      pc   = $urandom;
      tgt  = HB'($urandom_range(0, 15));
      hist = pc[HB+1:2] ^ tgt;
      ui   = ($urandom_range(0, 1) == 1) ? tgt : HB'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), pc, hist, 1'($urandom_range(0, 1)), ui, 1'($urandom_range(0, 1)));
    end

    // Mid-operation reset: train idx 3 to strong T, reset, reset again mid-sweep
    for (int k = 0; k < 3; k++) update(3, 1'b1);
    predict(3);
    apply_reset();
    for (int c = 0; c < 500; c++) tick();
    check("mid_ready", ready, 0);
    apply_reset();
    wait_init(1'b0);
    predict(3);
    check("mid_idx3_nt", pred_taken, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
